// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses a framed program (sync, length, words, checksum)
// and writes it word by word into instruction memory while holding the CPU in reset.
module imem_loader #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    input  logic          reload,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    len_hi;
    logic [15:0]   words_left;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;
    logic [AW-1:0] word_idx;
    logic [7:0]    csum;

    logic          accept;
    logic [15:0]   len_full;
    logic [7:0]    csum_sum;
    logic          last_byte_of_word;

    assign accept            = rx_valid && rx_ready;
    assign len_full          = {len_hi, rx_data};
    assign csum_sum          = csum + rx_data;
    assign last_byte_of_word = (byte_cnt == 2'd3);

    // Handshake and status are pure decodes of the state register.
    assign rx_ready = (state != DONE) && (state != ERR);
    assign cpu_hold = (state != DONE);
    assign done     = (state == DONE);
    assign error    = (state == ERR);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values; blocking here would create ordering races.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && rx_data == SYNC_BYTE) state_next = LEN_HI;
            end
            LEN_HI: begin
                if (accept) state_next = LEN_LO;
            end
            LEN_LO: begin
                if (accept) begin
                    if (len_full > 16'(DEPTH))  state_next = ERR;
                    else if (len_full == 16'd0) state_next = CSUM;
                    else                        state_next = DATA;
                end
            end
            DATA: begin
                if (accept && last_byte_of_word && words_left == 16'd1) state_next = CSUM;
            end
            CSUM: begin
                if (accept) state_next = (csum_sum == 8'd0) ? DONE : ERR;
            end
            DONE, ERR: begin
                if (reload) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, write strobe and running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi     <= '0;
            words_left <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            word_idx   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        csum     <= '0;
                        byte_cnt <= '0;
                        word_idx <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_hi <= rx_data;
                        csum   <= csum_sum;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        words_left <= len_full;
                        csum       <= csum_sum;
                    end
                end
                DATA: begin
                    if (accept) begin
                        csum     <= csum_sum;
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {shift[15:0], rx_data};
                        if (last_byte_of_word) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx;
                            imem_wdata <= {shift, rx_data};
                            word_idx   <= word_idx + AW'(1);
                            words_left <= words_left - 16'd1;
                        end
                    end
                end
                DONE, ERR: begin
                    if (reload) begin
                        csum     <= '0;
                        word_idx <= '0;
                        byte_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum error, overflow,
// gapped stream, full-depth load and mid-word reset recovery.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  sum;

    logic [31:0] prog [7];

    imem_loader #(.DEPTH(256), .AW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge after the byte transferred.
    task automatic send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        sum      = sum + b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send(w[31:24], gap);
        send(w[23:16], gap);
        send(w[15:8],  gap);
        send(w[7:0],   gap);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        sum      = 8'h00;
        prog[0] = 32'h11223344;
        prog[1] = 32'hDEADBEEF;
        prog[2] = 32'h00000001;
        prog[3] = 32'h80000000;
        prog[4] = 32'hCAFEF00D;
        prog[5] = 32'h0F0F0F0F;
        prog[6] = 32'hFFFFFFFF;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single-word program with good checksum
        clear_log();
        send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
        send_word(32'h00430820, 0);
        send(8'h94, 0);
        check("a_wr_count", 32'(wr_addr.size()), 32'd1);
        check("a_addr", 32'(wr_addr[0]), 32'd0);
        check("a_data", wr_data[0], 32'h00430820);
        check("a_done", 32'(done), 32'd1);
        check("a_error", 32'(error), 32'd0);
        check("a_cpu_hold", 32'(cpu_hold), 32'd0);
        check("a_rx_ready", 32'(rx_ready), 32'd0);
        pulse_reload();
        check("a_reload_hold", 32'(cpu_hold), 32'd1);
        check("a_reload_done", 32'(done), 32'd0);
        check("a_reload_ready", 32'(rx_ready), 32'd1);

        // Bad checksum: word still written, then ERR until reload
        clear_log();
        send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
        send_word(32'h00430820, 0);
        send(8'h95, 0);
        check("b_wr_count", 32'(wr_addr.size()), 32'd1);
        check("b_data", wr_data[0], 32'h00430820);
        check("b_error", 32'(error), 32'd1);
        check("b_done", 32'(done), 32'd0);
        check("b_cpu_hold", 32'(cpu_hold), 32'd1);
        check("b_rx_ready", 32'(rx_ready), 32'd0);
        pulse_reload();
        check("b_reload_error", 32'(error), 32'd0);
        check("b_reload_ready", 32'(rx_ready), 32'd1);

        // Leading junk discarded, empty program; reload mid-frame ignored
        clear_log();
        send(8'h12, 0); send(8'hA5, 0);
        pulse_reload();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        check("c_wr_count", 32'(wr_addr.size()), 32'd0);
        check("c_done", 32'(done), 32'd1);
        pulse_reload();

        // Length overflow N=257
        clear_log();
        send(8'hA5, 0); send(8'h01, 0); send(8'h01, 0);
        check("d_error", 32'(error), 32'd1);
        check("d_rx_ready", 32'(rx_ready), 32'd0);
        send(8'h00, 2);
        check("d_wr_count", 32'(wr_addr.size()), 32'd0);
        pulse_reload();

        // Seven words with 3-cycle gaps between bytes
        clear_log();
        send(8'hA5, 3);
        sum = 8'h00;
        send(8'h00, 3); send(8'h07, 3);
        for (int i = 0; i < 7; i++) send_word(prog[i], 3);
        send(8'(8'h00 - sum), 3);
        check("e_wr_count", 32'(wr_addr.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("e_addr%0d", i), 32'(wr_addr[i]), 32'(i));
            check($sformatf("e_data%0d", i), wr_data[i], prog[i]);
        end
        check("e_done", 32'(done), 32'd1);
        pulse_reload();

        // Full-depth load N=256
        clear_log();
        send(8'hA5, 0);
        sum = 8'h00;
        send(8'h01, 0); send(8'h00, 0);
        for (int i = 0; i < 256; i++) send_word({8'(i), 8'(~i), 8'(i), 8'h5A}, 0);
        send(8'(8'h00 - sum), 0);
        check("f_wr_count", 32'(wr_addr.size()), 32'd256);
        check("f_last_addr", 32'(wr_addr[255]), 32'd255);
        check("f_last_data", wr_data[255], 32'hFF00FF5A);
        check("f_done", 32'(done), 32'd1);
        pulse_reload();

        // Reset after the 2nd data byte with a byte in flight, then clean load
        clear_log();
        send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
        send(8'h00, 0); send(8'h43, 0);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h08;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        check("g_rst_ready", 32'(rx_ready), 32'd1);
        check("g_rst_hold", 32'(cpu_hold), 32'd1);
        check("g_rst_addr", 32'(imem_addr), 32'd0);
        check("g_rst_wdata", imem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        check("g_no_spurious", 32'(wr_addr.size()), 32'd0);
        send(8'hA5, 0); send(8'h00, 0); send(8'h01, 0);
        send_word(32'h00430820, 0);
        send(8'h94, 0);
        check("g_wr_count", 32'(wr_addr.size()), 32'd1);
        check("g_addr", 32'(wr_addr[0]), 32'd0);
        check("g_data", wr_data[0], 32'h00430820);
        check("g_done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 256: instruction-memory depth in 32-bit words.
REQ-002 Parameter AW, default 8: imem word-address width; DEPTH SHALL equal 2**AW.
REQ-003 Port clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port rx_valid  input  1  a byte is offered on rx_data.
REQ-006 Port rx_data  input  8  byte of the loader stream.
REQ-007 Port rx_ready  output  1  loader accepts a byte; transfer occurs on a cycle with rx_valid=1 and rx_ready=1.
REQ-008 Port reload  input  1  single-cycle request to restart loading from DONE or ERR.
REQ-009 Port imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 Port imem_addr  output  AW  word index written; word i lands at imem mem[i], byte address 4*i.
REQ-011 Port imem_wdata  output  32  assembled instruction word.
REQ-012 Port cpu_hold  output  1  holds cpu_top in reset while high.
REQ-013 Port done  output  1  load completed with a good checksum.
REQ-014 Port error  output  1  load aborted: bad checksum or length overflow.

Function
REQ-015 Stream format SHALL be: sync byte 0xA5, LEN_HI, LEN_LO (16-bit word count N), then N words of 4 bytes each, big-endian (first byte to bits 31:24), then one checksum byte.
REQ-016 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR.
REQ-017 IDLE: any accepted byte other than 0xA5 SHALL be discarded; 0xA5 SHALL move the FSM to LEN_HI.
REQ-018 LEN_HI to LEN_LO, then LEN_LO to DATA if N>0 or to CSUM if N=0, each on one accepted byte.
REQ-019 At the end of LEN_LO, N>DEPTH SHALL move the FSM to ERR; the remaining bytes of that stream are ignored.
REQ-020 DATA: a 2-bit byte counter SHALL shift bytes into a 32-bit assembly register; on acceptance of byte 3, imem_we SHALL pulse high in the following cycle with imem_wdata = the assembled word and imem_addr = word index.
REQ-021 The word index SHALL start at 0 and increment after each write; after word N-1 the FSM SHALL move to CSUM.
REQ-022 Checksum rule: the 8-bit modulo-256 sum of LEN_HI, LEN_LO, all data bytes and the checksum byte SHALL be 0x00; the sync byte is excluded.
REQ-023 CSUM: a correct sum SHALL move the FSM to DONE, otherwise to ERR.
REQ-024 rx_ready SHALL be 1 in IDLE, LEN_HI, LEN_LO, DATA and CSUM, and 0 in DONE and ERR; rx_ready SHALL be independent of rx_valid.
REQ-025 Cycles with rx_valid=0 SHALL leave all state unchanged (arbitrary gaps are allowed).
REQ-026 cpu_hold SHALL be 1 in every state except DONE; done=1 only in DONE; error=1 only in ERR.
REQ-027 reload=1 in DONE or ERR SHALL move the FSM to IDLE, clear the word index and the checksum, and raise cpu_hold on the next cycle; reload SHALL be ignored in other states.
REQ-028 Words already written before an ERR SHALL remain in imem; no rollback.

Reset
REQ-029 rst=1 SHALL force IDLE with imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, cpu_hold=1, rx_ready=1 after the next edge.
REQ-030 rst SHALL override reload and any in-flight byte, including a mid-word DATA reset; no imem_we pulse may follow that reset.

Verification
REQ-031 Stream A5 00 01 00 43 08 20 94 -> exactly one imem_we pulse with addr 0 and wdata 0x00430820, then done=1, cpu_hold=0, rx_ready=0.
REQ-032 Same stream with checksum 0x95 -> word 0 written, then error=1, done=0, cpu_hold=1; reload pulse -> IDLE, error=0.
REQ-033 Stream 12 A5 00 00 00 -> leading 0x12 discarded, no writes, done=1.
REQ-034 Stream A5 01 01 (N=257 > 256) -> error=1 immediately after LEN_LO, no imem_we.
REQ-035 Seven-word program with rx_valid deasserted for 3 cycles between every byte -> addrs 0..6 written in order, words intact, done=1.
REQ-036 rst asserted after the 2nd data byte, then the full stream of REQ-031 is sent -> clean load of 0x00430820 at addr 0 with no spurious write.
